// File: rtl/lcg_pkg.sv
// Shared constants, default LCG coefficients and engine state type.
package lcg_pkg;

    localparam int unsigned LCG_WIDTH = 64;
    localparam int unsigned LCG_SHW   = 6;

    localparam logic [LCG_WIDTH-1:0] LCG_A_DEFAULT = 64'h5851F42D4C957F2D;
    localparam logic [LCG_WIDTH-1:0] LCG_C_DEFAULT = 64'h14057B7EF767814F;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } lcg_state_e;

endpackage

// File: rtl/lcg_step_engine_if.sv
// Seed/config load, start request and result handshake of the LCG step engine.
interface lcg_step_engine_if;
    import lcg_pkg::*;

    logic                 seed_load;
    logic [LCG_WIDTH-1:0] seed;
    logic [LCG_WIDTH-1:0] mult;
    logic [LCG_WIDTH-1:0] incr;
    logic                 start;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [LCG_WIDTH-1:0] rand_out;

    modport master (
        output seed_load, seed, mult, incr, start, out_ready,
        input  busy, out_valid, rand_out
    );

    modport slave (
        input  seed_load, seed, mult, incr, start, out_ready,
        output busy, out_valid, rand_out
    );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational logarithmic left barrel shifter, zero fill.
module BarrelShifter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift
);

    // One conditional power-of-two shift stage per shift-amount bit.
    always_comb begin
        out = in;
        for (int unsigned i = 0; i < SHW; i++) begin
            if (shift[i]) begin
                out = out << (1 << i);
            end
        end
    end

endmodule

// File: rtl/lcg_step_engine.sv
// Shift-and-add LCG step: x_next = (mult * x + incr) mod 2^64, one multiplier bit per cycle.
module lcg_step_engine
    import lcg_pkg::*;
#(
    parameter int unsigned WIDTH = LCG_WIDTH,
    parameter int unsigned SHW   = LCG_SHW
) (
    input  logic              clk,
    input  logic              reset,
    lcg_step_engine_if.slave  bus
);

    lcg_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [WIDTH-1:0] c_reg_q, c_reg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0] rand_q, rand_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] acc_sum;

    BarrelShifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .out   (shifted),
        .in    (x_q),
        .shift (idx_q)
    );

    // Next-state, datapath update and handshake outputs; seed_load overrides every state.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_reg_d = a_reg_q;
        c_reg_d = c_reg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        rand_d  = rand_q;

        term    = a_reg_q[idx_q] ? shifted : '0;
        acc_sum = acc_q + term;

        if (bus.seed_load) begin
            x_d     = bus.seed;
            a_reg_d = bus.mult;
            c_reg_d = bus.incr;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_d   = c_reg_q;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = acc_sum;
                    idx_d = idx_q + SHW'(1);
                    if (idx_q == '1) begin
                        x_d     = acc_sum;
                        rand_d  = acc_sum;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        bus.busy      = (state_q == RUN) || (state_q == HOLD);
        bus.out_valid = (state_q == HOLD);
        bus.rand_out  = rand_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            a_reg_q <= LCG_A_DEFAULT;
            c_reg_q <= LCG_C_DEFAULT;
            acc_q   <= '0;
            idx_q   <= '0;
            rand_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_reg_q <= a_reg_d;
            c_reg_q <= c_reg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            rand_q  <= rand_d;
        end
    end

endmodule

// File: tb/tb_lcg_step_engine.sv
// Self-checking bench for lcg_step_engine against a plain-arithmetic LCG model.
module tb_lcg_step_engine;

    localparam logic [63:0] A_DEF = 64'h5851F42D4C957F2D;
    localparam logic [63:0] C_DEF = 64'h14057B7EF767814F;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lcg_step_engine_if bus ();

    lcg_step_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: state and coefficients as plain 64-bit integers.
    longint unsigned m_x;
    longint unsigned m_a;
    longint unsigned m_c;

    int vectors = 0;
    int errors  = 0;

    function automatic longint unsigned model_next();
        return m_a * m_x + m_c;
    endfunction

    task automatic model_reset();
        m_x = 0;
        m_a = A_DEF;
        m_c = C_DEF;
    endtask

    task automatic load(input logic [63:0] s, input logic [63:0] m, input logic [63:0] i);
        bus.seed_load = 1'b1;
        bus.seed      = s;
        bus.mult      = m;
        bus.incr      = i;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_x = s;
        m_a = m;
        m_c = i;
    endtask

    // Pulse start and count cycles until out_valid (bounded).
    task automatic issue_start(output int cyc);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rand_out !== 64'h0) begin
            errors++;
            $display("FAIL reset: busy=%b out_valid=%b rand_out=%h required 0 0 0",
                     bus.busy, bus.out_valid, bus.rand_out);
        end
    endtask

    task automatic test_default_word();
        int cyc;
        longint unsigned exp;
        exp = model_next();
        issue_start(cyc);
        vectors++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL default_latency: got %0d required 64", cyc);
        end
        vectors++;
        if (bus.rand_out !== C_DEF || bus.rand_out !== exp) begin
            errors++;
            $display("FAIL default_word: got %h required %h", bus.rand_out, C_DEF);
        end
        m_x = exp;
        accept();
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL default_handshake: busy=%b out_valid=%b required 0 0",
                     bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_small();
        int cyc;
        longint unsigned exp;
        load(64'd1, 64'd3, 64'd5);
        exp = model_next();
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== 64'd8 || exp != 64'd8) begin
            errors++;
            $display("FAIL small_first: got %0d required 8", bus.rand_out);
        end
        m_x = exp;
        accept();
        exp = model_next();
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== 64'd29 || exp != 64'd29) begin
            errors++;
            $display("FAIL small_second: got %0d required 29", bus.rand_out);
        end
        m_x = exp;
        accept();
    endtask

    task automatic test_wrap();
        int cyc;
        load(64'd1, '1, 64'd0);
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("FAIL wrap_ones: got %h required ffffffffffffffff", bus.rand_out);
        end
        accept();
        load(64'd2, '1, 64'd0);
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== 64'hFFFFFFFFFFFFFFFE || model_next() != 64'hFFFFFFFFFFFFFFFE) begin
            errors++;
            $display("FAIL wrap_twos: got %h required fffffffffffffffe", bus.rand_out);
        end
        m_x = model_next();
        accept();
    endtask

    task automatic test_stall();
        int cyc;
        longint unsigned exp;
        load({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        exp = model_next();
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== exp) begin
            errors++;
            $display("FAIL stall_word: got %h required %h", bus.rand_out, exp);
        end
        m_x = exp;
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 5);
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.rand_out !== exp) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b rand_out=%h required 1 %h",
                         i, bus.out_valid, bus.rand_out, exp);
            end
        end
        bus.start = 1'b0;
        accept();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL stall_release[%0d]: out_valid=%b busy=%b required 0 0",
                         i, bus.out_valid, bus.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort_load();
        int cyc;
        bit saw_valid;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        load(64'd7, 64'd2, 64'd0);
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b out_valid=%b required 0 0", bus.busy, bus.out_valid);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid seen=%b required 0", saw_valid);
        end
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== 64'd14 || model_next() != 64'd14) begin
            errors++;
            $display("FAIL abort_restart: got %0d required 14", bus.rand_out);
        end
        m_x = model_next();
        accept();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rand_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b out_valid=%b rand_out=%h required 0 0 0",
                     bus.busy, bus.out_valid, bus.rand_out);
        end
        issue_start(cyc);
        vectors++;
        if (bus.rand_out !== C_DEF || model_next() != C_DEF) begin
            errors++;
            $display("FAIL reset_restart: got %h required %h", bus.rand_out, C_DEF);
        end
        m_x = model_next();
        accept();
    endtask

    task automatic test_back_to_back_random();
        int cyc;
        longint unsigned exp;
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                load({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
            end
            exp = model_next();
            issue_start(cyc);
            vectors++;
            if (cyc !== 64 || bus.rand_out !== exp) begin
                errors++;
                $display("FAIL random[%0d]: latency=%0d rand_out=%h required 64 %h",
                         n, cyc, bus.rand_out, exp);
            end
            m_x = exp;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.seed_load = 1'b0;
        bus.seed      = '0;
        bus.mult      = '0;
        bus.incr      = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        test_reset();
        test_default_word();
        test_small();
        test_wrap();
        test_stall();
        test_abort_load();
        test_reset_mid_run();
        test_back_to_back_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lcg_step_engine.md
# lcg_step_engine

Sequential multiply-accumulate engine that advances a 64-bit linear congruential generator state, x_next = (mult·x + incr) mod 2^64, using shift-and-add. Each cycle it drives a 6-bit shift amount and the current state into the 64-bit left barrel shifter, then adds the shifted term into an accumulator. It is the stage directly upstream of the barrel shifter and delivers one pseudo-random word per request to the MDCLCG output logic over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 64, data width. Fixed to the shifter width and not to be overridden.
- SHW, 6, shift-amount width, log2(WIDTH).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- seed_load  input  1  one-cycle pulse that loads seed, mult and incr.
- seed  input  64  new LCG state.
- mult  input  64  LCG multiplier.
- incr  input  64  LCG increment.
- start  input  1  request the next word. Sampled only in IDLE.
- busy  output  1  high in RUN and HOLD.
- out_valid  output  1  rand_out is valid.
- out_ready  input  1  consumer accepts rand_out.
- rand_out  output  64  new state x_next.

## Operation
- Registers:
  - x (state)
  - a_reg (multiplier)
  - c_reg (increment)
  - acc (64-bit accumulator)
  - idx (6-bit bit index)
  - state
- States and transitions:
  - IDLE: if seed_load, load x←seed, a_reg←mult, c_reg←incr and stay in IDLE. Else if start, set acc←c_reg, idx←0 and go to RUN.
  - RUN: the shifter gets in=x and shift=idx. acc←acc + (a_reg[idx] ? shifted : 0), and idx←idx+1. When idx==63, perform the final add, then go to HOLD.
  - HOLD: x←acc and rand_out←acc are written on the RUN→HOLD edge. out_valid is high. When out_valid&out_ready, go to IDLE.
- Arithmetic: all adds wrap modulo 2^64, and carries out of bit 63 are discarded. The shifter fills with zeros, so bits shifted past bit 63 are lost. This is correct behaviour for mod 2^64.
- Every bit of a_reg is visited, including zero bits. Latency is data-independent.
- seed_load has priority in every state:
  - It loads the registers, forces IDLE and clears out_valid.
  - An in-flight computation is aborted and its result discarded.
- seed_load and start in the same IDLE cycle: the load happens and start is dropped.
- start outside IDLE is ignored. There is no queuing.
- rand_out and x stay stable throughout HOLD regardless of the inputs, except seed_load.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, busy=0, rand_out=0, x=0, acc=0, idx=0
  - a_reg=LCG_A_DEFAULT (64'h5851F42D4C957F2D)
  - c_reg=LCG_C_DEFAULT (64'h14057B7EF767814F)
- Reset mid-RUN or mid-HOLD returns to the reset values on the next edge.
- Latency: start sampled at edge k gives RUN on cycles k+1…k+64 (idx 0…63), and out_valid high from cycle k+65.
- Throughput: at least 66 cycles per word. The word is accepted at edge m, IDLE holds at m+1, and start is sampled at the earliest at edge m+1.
- out_valid, once asserted, stays high until the edge where out_ready=1. rand_out must not change while out_valid=1.
- busy rises on the cycle after start is accepted and falls on the cycle after the handshake.
- The critical path is the 64-bit shifter plus the 64-bit adder in one cycle. No internal pipelining.

## Structure
- Shared package lcg_pkg:
  - LCG_WIDTH=64 and LCG_SHW=6.
  - LCG_A_DEFAULT and LCG_C_DEFAULT.
  - The state enum {IDLE, RUN, HOLD}.
- Sub-module: one instance of the existing BarrelShifter (out, in, shift), combinational.
  - in=x, shift=idx.
  - Its output is gated by a_reg[idx] before the adder.
- Expected size: about 150 lines of RTL.

## Test plan
- Reset, then start with defaults (x=0) → out_valid at start+65, rand_out=64'h14057B7EF767814F.
- seed_load seed=1, mult=3, incr=5, then start → rand_out=8. Handshake, start again → 29.
- seed=1, mult=64'hFFFFFFFFFFFFFFFF, incr=0 → rand_out=64'hFFFFFFFFFFFFFFFF. seed=2 with the same mult/incr → 64'hFFFFFFFFFFFFFFFE (wrap).
- Hold out_ready=0 for 20 cycles after out_valid:
  - out_valid and rand_out stay constant.
  - A start pulse in that window is ignored.
  - Release gives exactly one transfer, then IDLE.
- seed_load at RUN cycle 30 with seed=7, mult=2, incr=0:
  - IDLE next cycle, out_valid never asserts for the aborted run.
  - A following start gives 14.
- reset asserted at RUN cycle 40 → all outputs reach reset values next edge. A following start gives 64'h14057B7EF767814F.
